seq_pattern_gen: RTL and testbench
==================================

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter DIV, default 1, clk cycles per serial bit, legal 1..255.
REQ-002 SHALL have parameter CW, default 10, width of frame count and sent counter.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin a burst; sampled on rising clk.
REQ-006 SHALL have port n_frames  input  CW  number of "010" frames to emit; latched at accepted start.
REQ-007 SHALL have port gap  input  4  idle-high bits after each frame; latched at accepted start; 0 treated as 1.
REQ-008 SHALL have port x_out  output  1  registered serial line; idle level 1.
REQ-009 SHALL have port busy  output  1  high while a burst is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-011 SHALL have port sent  output  CW  frames completed in the current or last burst.

Function
REQ-012 SHALL implement states IDLE, B0, B1, B2, GAP; each bit state holds x_out for exactly DIV cycles.
REQ-013 SHALL drive x_out: IDLE=1, B0=0, B1=1, B2=0, GAP=1, so a frame is 0,1,0 followed by gap_l ones.
REQ-014 SHALL accept start only when busy=0; start while busy=1 is ignored with no effect on latched values.
REQ-015 SHALL, on accepted start with n_frames>0, latch n_frames/gap, clear sent, set busy and enter B0; x_out=0 on the first cycle after the start edge.
REQ-016 SHALL, on accepted start with n_frames=0, stay in IDLE, keep x_out=1, clear sent, and pulse done on the next cycle without asserting busy.
REQ-017 SHALL transition B0->B1->B2->GAP after each DIV-cycle bit period.
REQ-018 SHALL increment sent by 1 on the cycle GAP is entered, i.e. when the closing 0 bit completes.
REQ-019 SHALL, after gap_l bit periods in GAP, return to B0 if sent < latched n_frames, else enter IDLE.
REQ-020 SHALL, on GAP->IDLE, deassert busy and pulse done in the same cycle; burst length = n_frames*(3+gap_l)*DIV cycles.
REQ-021 SHALL accept a start in the same cycle done is high, with the next burst's B0 beginning on the following cycle.
REQ-022 SHALL hold sent at its final value in IDLE until the next accepted start.
REQ-023 SHALL support n_frames = 2^CW-1 without counter overflow; sent never wraps within a burst.
REQ-024 SHALL produce a stream that a zero/one/store detector, starting from its idle state, counts as exactly n_frames events.

Reset
REQ-025 SHALL, while rst=1, force state IDLE, x_out=1, busy=0, done=0, sent=0 and clear the bit timer and gap counter.
REQ-026 SHALL, on rst asserted mid-burst, abandon the burst immediately with no done pulse; the line returns to 1.
REQ-027 SHALL ignore start while rst=1 and accept start on the first clk edge after rst deasserts.

Structure
REQ-028 SHALL take state encoding (IDLE=2'b11-style 3-bit localparams), IDLE_LEVEL=1 and the frame bit pattern from shared package fsm_pkg.
REQ-029 SHALL use one sub-module bit_timer (DIV-cycle prescaler with clear input and bit_tick output); the FSM and counters live in seq_pattern_gen.
REQ-030 SHALL register all outputs; no combinational path from inputs to outputs.

Verification
REQ-031 SHALL test DIV=1, n_frames=1, gap=1: x_out = 0,1,0,1 over cycles 1-4 after start; done at cycle 4; sent=1.
REQ-032 SHALL test DIV=3, n_frames=3, gap=2: each bit held 3 cycles; busy high 45 cycles; sent=3; reference detector count=3.
REQ-033 SHALL test n_frames=0: busy never asserted; done pulses 1 cycle after start; x_out stays 1; sent=0.
REQ-034 SHALL test start pulses while busy (n_frames=2 running, start with n_frames=7): burst still ends at sent=2.
REQ-035 SHALL test rst asserted during B1 of frame 2: x_out=1, busy=0, sent=0 immediately; no done; a later start with n_frames=1 behaves as REQ-031.
REQ-036 SHALL test back-to-back: start held high continuously with n_frames=2, gap=0: second burst begins the cycle after done; gap behaves as 1.

Source files
------------

// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared state encoding, line levels and frame pattern for the pattern generator
package fsm_pkg;

    localparam logic [2:0] ST_IDLE = 3'b011;
    localparam logic [2:0] ST_B0   = 3'b000;
    localparam logic [2:0] ST_B1   = 3'b001;
    localparam logic [2:0] ST_B2   = 3'b010;
    localparam logic [2:0] ST_GAP  = 3'b100;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        B0   = ST_B0,
        B1   = ST_B1,
        B2   = ST_B2,
        GAP  = ST_GAP
    } state_t;

    localparam logic       IDLE_LEVEL = 1'b1;
    // Frame bits in transmit order, MSB first: B0, B1, B2.
    localparam logic [2:0] FRAME_BITS = 3'b010;

    function automatic logic line_level(input state_t s);
        case (s)
            B0:      return FRAME_BITS[2];
            B1:      return FRAME_BITS[1];
            B2:      return FRAME_BITS[0];
            default: return IDLE_LEVEL;
        endcase
    endfunction

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - DIV-cycle prescaler; bit_tick marks the last cycle of each bit period
module bit_timer #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - bursts of "010" serial frames, each followed by gap idle-high bits
module seq_pattern_gen #(
    parameter int DIV = 1,
    parameter int CW  = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] n_frames,
    input  logic [3:0]    gap,
    output logic          x_out,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] sent
);
    import fsm_pkg::*;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] n_l;
    logic [CW-1:0] n_l_n;
    logic [CW-1:0] sent_n;
    logic [3:0]    gap_l;
    logic [3:0]    gap_l_n;
    logic [3:0]    gap_cnt;
    logic [3:0]    gap_cnt_n;
    logic          done_n;
    logic          timer_clr;
    logic          bit_tick;

    bit_timer #(.DIV(DIV)) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clr),
        .bit_tick (bit_tick)
    );

    // The timer is held cleared in IDLE so B0 always starts a full bit period.
    always_comb begin
        state_n   = state;
        n_l_n     = n_l;
        gap_l_n   = gap_l;
        gap_cnt_n = gap_cnt;
        sent_n    = sent;
        done_n    = 1'b0;
        timer_clr = 1'b0;
        case (state)
            IDLE: begin
                timer_clr = 1'b1;
                if (start) begin
                    sent_n = '0;
                    if (n_frames != '0) begin
                        n_l_n     = n_frames;
                        gap_l_n   = (gap == 4'd0) ? 4'd1 : gap;
                        gap_cnt_n = '0;
                        state_n   = B0;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            B0: if (bit_tick) state_n = B1;
            B1: if (bit_tick) state_n = B2;
            B2: begin
                if (bit_tick) begin
                    state_n   = GAP;
                    sent_n    = sent + CW'(1);
                    gap_cnt_n = '0;
                end
            end
            GAP: begin
                if (bit_tick) begin
                    if (gap_cnt == gap_l - 4'd1) begin
                        gap_cnt_n = '0;
                        if (sent < n_l) begin
                            state_n = B0;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        gap_cnt_n = gap_cnt + 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so x_out leads with no extra cycle of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            n_l     <= '0;
            gap_l   <= 4'd1;
            gap_cnt <= '0;
            sent    <= '0;
            x_out   <= IDLE_LEVEL;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            n_l     <= n_l_n;
            gap_l   <= gap_l_n;
            gap_cnt <= gap_cnt_n;
            sent    <= sent_n;
            x_out   <= line_level(state_n);
            busy    <= (state_n != IDLE);
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - scoreboard bench for seq_pattern_gen at DIV=1 and DIV=3
module tb_seq_pattern_gen;

    localparam int CW = 4;
    localparam int NI = 2;

    typedef struct {
        int n;
        int g;
        int c;
    } burst_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] n_frames = '0;
    logic [3:0]    gap = '0;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    int free_at [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int D = (gi == 0) ? 1 : 3;

        logic          x_out;
        logic          busy;
        logic          done;
        logic [CW-1:0] sent;
        burst_t        exp_q [$];
        logic          cap_x [$];
        int            cap_s [$];
        int            idle_bad = 0;
        int            exp_idle_sent = 0;

        seq_pattern_gen #(.DIV(D), .CW(CW)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .n_frames (n_frames),
            .gap      (gap),
            .x_out    (x_out),
            .busy     (busy),
            .done     (done),
            .sent     (sent)
        );

        function automatic string nm(input string s);
            return $sformatf("%s_div%0d", s, D);
        endfunction

        // A burst is judged as a whole when its done pulse appears.
        task automatic judge();
            burst_t b;
            int     p;
            int     l;
            int     wave_bad;
            int     sent_bad;
            int     det;
            int     i;
            logic   bits [$];
            if (exp_q.size() == 0) begin
                check(nm("unexpected_done"), 32'd1, 32'd0);
                cap_x.delete();
                cap_s.delete();
                return;
            end
            b = exp_q.pop_front();
            p = (3 + b.g) * D;
            l = b.n * p;
            check(nm("done_time"), cyc, b.c + l);
            check(nm("done_busy"), {31'd0, busy}, 32'd0);
            check(nm("done_x"), {31'd0, x_out}, 32'd1);
            check(nm("final_sent"), {28'd0, sent}, b.n);
            check(nm("busy_len"), cap_x.size(), l);
            wave_bad = 0;
            sent_bad = 0;
            for (int k = 0; k < cap_x.size() && k < l; k++) begin
                int   ph = k % p;
                logic ex = (ph < 3 * D) ? ((ph / D) == 1) : 1'b1;
                int   es = k / p + ((ph >= 3 * D) ? 1 : 0);
                if (cap_x[k] !== ex) wave_bad++;
                if (cap_s[k] != es) sent_bad++;
            end
            check(nm("wave_errs"), wave_bad, 0);
            check(nm("sent_track_errs"), sent_bad, 0);
            for (int k = 0; k < cap_x.size(); k += D) bits.push_back(cap_x[k]);
            det = 0;
            i = 0;
            while (i + 2 < bits.size()) begin
                if (bits[i] == 1'b0 && bits[i+1] == 1'b1 && bits[i+2] == 1'b0) begin
                    det++;
                    i += 3;
                end else begin
                    i++;
                end
            end
            check(nm("detector_count"), det, b.n);
            exp_idle_sent = b.n;
            cap_x.delete();
            cap_s.delete();
        endtask

        always @(negedge clk) begin
            if (rst) begin
                cap_x.delete();
                cap_s.delete();
                exp_idle_sent = 0;
            end else if (busy) begin
                cap_x.push_back(x_out);
                cap_s.push_back(int'(sent));
                if (done) idle_bad++;
            end else if (done) begin
                judge();
            end else if (x_out !== 1'b1 || int'(sent) != exp_idle_sent) begin
                idle_bad++;
            end
        end
    end

    task automatic push_exp(input int i, input burst_t b);
        if (i == 0) g_inst[0].exp_q.push_back(b);
        else        g_inst[1].exp_q.push_back(b);
    endtask

    // One cycle of stimulus; the model decides which instances accept the start.
    task automatic step(input logic s, input int n, input int g);
        int     c = cyc + 1;
        burst_t b;
        start    = s;
        n_frames = CW'(n);
        gap      = 4'(g);
        if (s && !rst) begin
            for (int i = 0; i < NI; i++) begin
                if (c >= free_at[i]) begin
                    b.n = n;
                    b.g = (g == 0) ? 1 : g;
                    b.c = c;
                    push_exp(i, b);
                    free_at[i] = c + n * (3 + b.g) * div_of(i) + 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int tmo = 0;
        while ((cyc + 1 < free_at[0] || cyc + 1 < free_at[1]) && tmo < 2000) begin
            step(1'b0, 0, 0);
            tmo++;
        end
        step(1'b0, 0, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_x_div1"},    {31'd0, g_inst[0].x_out}, 32'd1);
        check({tag, "_busy_div1"}, {31'd0, g_inst[0].busy},  32'd0);
        check({tag, "_done_div1"}, {31'd0, g_inst[0].done},  32'd0);
        check({tag, "_sent_div1"}, {28'd0, g_inst[0].sent},  32'd0);
        check({tag, "_x_div3"},    {31'd0, g_inst[1].x_out}, 32'd1);
        check({tag, "_busy_div3"}, {31'd0, g_inst[1].busy},  32'd0);
        check({tag, "_done_div3"}, {31'd0, g_inst[1].done},  32'd0);
        check({tag, "_sent_div3"}, {28'd0, g_inst[1].sent},  32'd0);
    endtask

    initial begin
        int drain;
        free_at[0] = 0;
        free_at[1] = 0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        step(1'b0, 0, 0);

        step(1'b1, 1, 1);
        wait_idle();
        step(1'b1, 3, 2);
        wait_idle();
        step(1'b1, 0, 4);
        wait_idle();

        // Starts arriving while busy must not disturb the running burst.
        step(1'b1, 2, 1);
        repeat (2) step(1'b0, 0, 0);
        repeat (2) step(1'b1, 7, 5);
        wait_idle();

        // Reset lands in B1 of frame 2 on the DIV=3 instance.
        step(1'b1, 2, 1);
        repeat (16) step(1'b0, 0, 0);
        check("pre_reset_x_div3", {31'd0, g_inst[1].x_out}, 32'd1);
        check("pre_reset_busy_div3", {31'd0, g_inst[1].busy}, 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_state("midburst_reset");
        g_inst[0].exp_q.delete();
        g_inst[1].exp_q.delete();
        free_at[0] = 0;
        free_at[1] = 0;
        @(negedge clk);
        repeat (2) step(1'b1, 5, 3);
        rst = 1'b0;
        step(1'b1, 1, 1);
        step(1'b0, 0, 0);
        wait_idle();

        repeat (52) step(1'b1, 2, 0);
        wait_idle();
        step(1'b1, 15, 0);
        wait_idle();

        for (int it = 0; it < 25; it++) begin
            step(1'b1, int'($urandom_range(0, 6)), int'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 40))
                step($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end
        wait_idle();

        drain = 0;
        while ((g_inst[0].exp_q.size() != 0 || g_inst[1].exp_q.size() != 0) && drain < 200) begin
            step(1'b0, 0, 0);
            drain++;
        end
        check("pending_bursts_div1", g_inst[0].exp_q.size(), 0);
        check("pending_bursts_div3", g_inst[1].exp_q.size(), 0);
        check("idle_violations_div1", g_inst[0].idle_bad, 0);
        check("idle_violations_div3", g_inst[1].idle_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
